// File: rtl/hcsr04_echo_meter.sv
// HC-SR04 front end: fires the trigger once per period, times the echo
// pulse in microseconds and reports distance in 0.01 mm units (us * 17).
module hcsr04_echo_meter #(
  parameter int CLK_FREQ_MHZ    = 50,
  parameter int TRIG_US         = 10,
  parameter int PERIOD_MS       = 60,
  parameter int ECHO_TIMEOUT_US = 25000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        echo,
  output logic        trig,
  output logic [18:0] data_out,
  output logic        data_valid,
  output logic        timeout
);

  localparam int PERIOD_CYC = PERIOD_MS * 1000 * CLK_FREQ_MHZ;
  localparam int PW         = $clog2(PERIOD_CYC);
  localparam int PSW        = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;

  localparam logic [PW-1:0]  PERIOD_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [PSW-1:0] PRESC_LAST  = PSW'(CLK_FREQ_MHZ - 1);
  localparam logic [14:0]    TRIG_LAST   = 15'(TRIG_US - 1);
  localparam logic [14:0]    TIMEOUT_US  = 15'(ECHO_TIMEOUT_US);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic           sync1_q, sync2_q, echo_dly_q;
  logic [PW-1:0]  period_q, period_d;
  logic [PSW-1:0] presc_q, presc_d;
  logic [14:0]    us_q, us_d;
  logic [14:0]    meas_next;
  logic           trig_q, trig_d;
  logic [18:0]    data_q, data_d;
  logic           valid_q, valid_d;
  logic           timeout_q, timeout_d;
  logic           us_tick, echo_rise, echo_fall;

  assign us_tick   = (presc_q == PRESC_LAST);
  // Edges compare the synchronized level against its one-cycle-delayed copy.
  assign echo_rise = sync2_q & ~echo_dly_q;
  assign echo_fall = ~sync2_q & echo_dly_q;
  // While measuring, the delayed level covers the fall-detect cycle, so the
  // tick count equals floor(high cycles / CLK_FREQ_MHZ).
  assign meas_next = us_q + {14'd0, us_tick & echo_dly_q};
  assign period_d  = (period_q == PERIOD_LAST) ? '0 : period_q + 1'b1;

  assign trig       = trig_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign timeout    = timeout_q;

  // Two-flop synchronizer for the asynchronous echo plus the edge-reference flop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      echo_dly_q <= 1'b0;
    end else begin
      sync1_q    <= echo;
      sync2_q    <= sync1_q;
      echo_dly_q <= sync2_q;
    end
  end

  // Free-running trigger period counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      period_q <= '0;
    end else begin
      period_q <= period_d;
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      us_q      <= '0;
      trig_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      us_q      <= us_d;
      trig_q    <= trig_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic; the prescaler restarts whenever a timed state is entered.
  always_comb begin
    state_d   = state_q;
    presc_d   = us_tick ? '0 : presc_q + 1'b1;
    us_d      = us_q;
    trig_d    = trig_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (period_q == '0) begin
          state_d = S_TRIG;
          trig_d  = 1'b1;
          presc_d = '0;
          us_d    = '0;
        end
      end
      S_TRIG: begin
        if (us_tick) begin
          if (us_q == TRIG_LAST) begin
            state_d = S_WAIT_RISE;
            trig_d  = 1'b0;
            presc_d = '0;
            us_d    = '0;
          end else begin
            us_d = us_q + 1'b1;
          end
        end
      end
      S_WAIT_RISE: begin
        // Only a fresh rising edge starts a measurement; a level already high is ignored.
        if (echo_rise) begin
          state_d = S_MEASURE;
          presc_d = '0;
          us_d    = '0;
        end else if (us_tick) begin
          if (us_q == TIMEOUT_US - 15'd1) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
          end else begin
            us_d = us_q + 1'b1;
          end
        end
      end
      S_MEASURE: begin
        us_d = meas_next;
        if (meas_next == TIMEOUT_US) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else if (echo_fall) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // us * 17 as a shift-add; the largest count still fits in 19 bits.
        data_d  = ({4'd0, us_q} << 4) + {4'd0, us_q};
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hcsr04_echo_meter.sv
// Randomized scoreboard bench for hcsr04_echo_meter at scaled-down timing.
module tb_hcsr04_echo_meter;

  localparam int CLK_MHZ  = 2;
  localparam int TRIG_US  = 5;
  localparam int PER_MS   = 1;
  localparam int TO_US    = 300;
  localparam int P_CYC    = PER_MS * 1000 * CLK_MHZ;
  localparam int TRIG_CYC = TRIG_US * CLK_MHZ;
  localparam int TO_CYC   = TO_US * CLK_MHZ;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        echo = 1'b0;
  logic        trig;
  logic [18:0] data_out;
  logic        data_valid;
  logic        timeout;

  hcsr04_echo_meter #(
    .CLK_FREQ_MHZ   (CLK_MHZ),
    .TRIG_US        (TRIG_US),
    .PERIOD_MS      (PER_MS),
    .ECHO_TIMEOUT_US(TO_US)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .echo      (echo),
    .trig      (trig),
    .data_out  (data_out),
    .data_valid(data_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_to;
    int data;
    int at_cyc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   rst_edge = 1'b0;
  int   held = 0;
  int   last_rise = -1;
  int   first_rise_exp = -1;
  bit   prev_trig = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= ~rstn;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe and tracks trig timing.
  always @(negedge clk) begin
    exp_t e;
    if (rst_edge) begin
      check("rst_trig", {31'd0, trig}, 0);
      check("rst_data_out", {13'd0, data_out}, 0);
      check("rst_data_valid", {31'd0, data_valid}, 0);
      check("rst_timeout", {31'd0, timeout}, 0);
      held = 0;
      q.delete();
      last_rise = -1;
      prev_trig = 1'b0;
    end else begin
      if (data_valid || timeout) begin
        check("strobe_exclusive", {31'd0, data_valid & timeout}, 0);
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe: got valid=%0d timeout=%0d, expected none (cycle %0d)",
                   data_valid, timeout, cyc);
        end else begin
          e = q.pop_front();
          check("strobe_kind_timeout", {31'd0, timeout}, {31'd0, e.is_to});
          if (!e.is_to) begin
            held = e.data;
            check("result_data_out", {13'd0, data_out}, e.data);
          end
          if (e.at_cyc >= 0) check("timeout_cycle", cyc, e.at_cyc);
        end
      end
      check("data_out_hold", {13'd0, data_out}, held);
      if (trig && !prev_trig) begin
        if (first_rise_exp >= 0) begin
          check("first_trig_after_reset", cyc, first_rise_exp);
          first_rise_exp = -1;
        end else if (last_rise >= 0) begin
          check("trig_period", cyc - last_rise, P_CYC);
        end
        last_rise = cyc;
      end
      if (!trig && prev_trig) check("trig_width", cyc - last_rise, TRIG_CYC);
      prev_trig = trig;
    end
  end

  task automatic wait_fall(output int fc);
    bit p;
    int n;
    bit ok;
    p  = trig;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 3 * P_CYC) begin
      @(negedge clk);
      n++;
      if (p && !trig) ok = 1'b1;
      p = trig;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL trig_fall_wait: got no fall in %0d cycles, expected one", 3 * P_CYC);
    end
    fc = cyc;
  endtask

  task automatic push_exp(input bit is_to, input int data, input int at_cyc);
    exp_t e;
    e.is_to  = is_to;
    e.data   = data;
    e.at_cyc = at_cyc;
    q.push_back(e);
  endtask

  // Echo of h cycles starting d cycles after trig falls.
  task automatic run_echo(input int d, input int h);
    int fc;
    int us;
    wait_fall(fc);
    repeat (d) @(negedge clk);
    echo = 1'b1;
    us = h / CLK_MHZ;
    if (us >= TO_US) push_exp(1'b1, 0, -1);
    else push_exp(1'b0, us * 17, -1);
    repeat (h) @(negedge clk);
    echo = 1'b0;
  endtask

  task automatic run_none();
    int fc;
    wait_fall(fc);
    push_exp(1'b1, 0, fc + TO_CYC);
  endtask

  // Echo stuck high through a measurement and the whole next wait window.
  task automatic run_held(input int d);
    int fc;
    wait_fall(fc);
    repeat (d) @(negedge clk);
    echo = 1'b1;
    push_exp(1'b1, 0, -1);
    wait_fall(fc);
    push_exp(1'b1, 0, fc + TO_CYC);
    repeat (TO_CYC + 10) @(negedge clk);
    echo = 1'b0;
  endtask

  task automatic run_reset_mid();
    int fc;
    wait_fall(fc);
    repeat (4) @(negedge clk);
    echo = 1'b1;
    repeat (100) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    echo = 1'b0;
    first_rise_exp = cyc + 1;
  endtask

  task automatic run_random();
    if ($urandom_range(0, 5) == 0) run_none();
    else run_echo(int'($urandom_range(0, 40)), int'($urandom_range(1, 700)));
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    echo = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    first_rise_exp = cyc + 1;

    run_echo(100 * CLK_MHZ, 100 * CLK_MHZ);   // 100 us echo -> 1700
    run_echo(5, 1);                           // sub-us echo -> 0
    run_none();                               // timeout, data_out holds 0
    run_echo(3, 200 * CLK_MHZ);               // 200 us -> 3400
    run_none();                               // timeout, data_out holds 3400
    run_echo(3, TO_CYC - 1);                  // 299 us -> 5083
    run_echo(3, TO_CYC);                      // reaches limit -> timeout
    run_echo(0, 2);                           // 1 us -> 17
    run_held(7);
    for (int i = 0; i < 8; i++) run_random();
    run_reset_mid();
    for (int i = 0; i < 2; i++) run_random();

    n = 0;
    while (q.size() != 0 && n < 2 * P_CYC) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending_results: got %0d outstanding, expected 0", q.size());
    end
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
